// File: rtl/exp_result_buffer_pkg.sv
// Shared constants for the exp result buffer and the display top level.
// Results are Q2.16: two integer bits above sixteen fraction bits.
package exp_result_buffer_pkg;

  localparam int DATA_W = 18;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int CW     = 4;

  // Q2.16 field positions
  localparam int Q_INT_MSB  = 17;
  localparam int Q_INT_LSB  = 16;
  localparam int Q_FRAC_MSB = 15;
  localparam int Q_FRAC_LSB = 0;

  typedef logic [DATA_W-1:0] q2_16_t;

  // Integer part of a Q2.16 value, for display formatting
  function automatic logic [1:0] q_int_part(input q2_16_t v);
    return v[Q_INT_MSB:Q_INT_LSB];
  endfunction

  // Fraction part of a Q2.16 value, for display formatting
  function automatic logic [15:0] q_frac_part(input q2_16_t v);
    return v[Q_FRAC_MSB:Q_FRAC_LSB];
  endfunction

endpackage

// File: rtl/exp_result_buffer_if.sv
// Handshake bundle between the accelerator/key side and the result buffer.
interface exp_result_buffer_if #(
  parameter int DATA_W = exp_result_buffer_pkg::DATA_W
);
  logic              start;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              wr_ready;
  logic              read;
  logic [DATA_W-1:0] q;
  logic [2:0]        usedw;
  logic              full;
  logic              empty;
  logic              ovf;

  // Producer / consumer side
  modport master (
    output start, res_valid, res_data, read,
    input  wr_ready, q, usedw, full, empty, ovf
  );

  // Buffer side
  modport slave (
    input  start, res_valid, res_data, read,
    output wr_ready, q, usedw, full, empty, ovf
  );
endinterface

// File: rtl/exp_result_buffer_regfile.sv
// Result storage: register array, one synchronous write port and one
// asynchronous read port. Contents are never reset.
module result_regfile #(
  parameter int DATA_W = exp_result_buffer_pkg::DATA_W,
  parameter int DEPTH  = exp_result_buffer_pkg::DEPTH,
  parameter int AW     = exp_result_buffer_pkg::AW
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  import exp_result_buffer_pkg::*;

  logic [DATA_W-1:0] mem [DEPTH];

  // Store the incoming result at the write address
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Show-ahead read of the addressed entry
  assign rdata = mem[raddr];

endmodule

// File: rtl/exp_result_buffer.sv
// Eight-entry show-ahead result buffer between the exp accelerator and a
// key-driven display. One pop per key press, sticky overflow, start flush.
module exp_result_buffer #(
  parameter int DATA_W = exp_result_buffer_pkg::DATA_W,
  parameter int DEPTH  = exp_result_buffer_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  exp_result_buffer_if.slave bus
);
  import exp_result_buffer_pkg::*;

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          read_d_reg;
  logic          ovf_reg;

  logic full;
  logic empty;
  logic wr_en;
  logic pop_evt;
  logic pop_en;
  logic mem_we;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign wr_en   = bus.res_valid && !full;
  assign pop_evt = bus.read && !read_d_reg;
  assign pop_en  = pop_evt && !empty;
  // A flush or an active reset swallows the write on that edge
  assign mem_we  = wr_en && !bus.start && rst;

  // Occupancy after this cycle's write/pop pair
  always_comb begin
    count_next = count_reg;
    case ({wr_en, pop_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Key edge detector runs independent of flush so a held key never re-pops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_d_reg <= 1'b0;
    end else begin
      read_d_reg <= bus.read;
    end
  end

  // Pointers, count and sticky overflow; start overrides writes and pops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else if (bus.start) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      if (bus.res_valid && full) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  result_regfile #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_ptr_reg),
    .wdata(bus.res_data),
    .raddr(rd_ptr_reg),
    .rdata(bus.q)
  );

  assign bus.wr_ready = !full;
  assign bus.usedw    = count_reg[AW-1:0];
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.ovf      = ovf_reg;

endmodule

// File: tb/tb_exp_result_buffer.sv
// Self-checking bench for exp_result_buffer against a queue-based model.
module tb_exp_result_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  exp_result_buffer_if #(.DATA_W(18)) bus();

  exp_result_buffer #(.DATA_W(18), .DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue, plus flag and key history
  logic [17:0] mq[$];
  logic        m_ovf    = 1'b0;
  logic        m_read_d = 1'b0;

  task automatic model_reset();
    mq.delete();
    m_ovf    = 1'b0;
    m_read_d = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, land 1 time unit past the edge
  task automatic step(input logic sv, input logic [17:0] d, input logic rd, input logic st);
    logic was_full;
    logic press;
    bus.res_valid = sv;
    bus.res_data  = d;
    bus.read      = rd;
    bus.start     = st;
    was_full = (mq.size() == 8);
    press    = rd && !m_read_d;
    if (st) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (sv && was_full) m_ovf = 1'b1;
      if (press && mq.size() > 0) void'(mq.pop_front());
      if (sv && !was_full) mq.push_back(d);
    end
    m_read_d = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 18'h0, 1'b0, 1'b0);
  endtask

  task automatic pop_once();
    step(1'b0, 18'h0, 1'b1, 1'b0);
    idle();
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0; bus.read = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.usedw !== 3'd0) begin errors++; $display("FAIL reset_usedw got %0d want 0", bus.usedw); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
    rst = 1'b1;
    model_reset();
    idle();
    $display("test_reset done");
  endtask

  task automatic test_basic_write();
    step(1'b1, 18'h10000, 1'b0, 1'b0);
    checks++; if (bus.q !== 18'h10000) begin errors++; $display("FAIL first_write_latency q=%h want 10000", bus.q); end
    step(1'b1, 18'h0B852, 1'b0, 1'b0);
    step(1'b1, 18'h2A000, 1'b0, 1'b0);
    idle();
    checks++; if (bus.usedw !== 3'd3) begin errors++; $display("FAIL basic_usedw got %0d want 3", bus.usedw); end
    checks++; if (bus.q !== 18'h10000) begin errors++; $display("FAIL basic_q got %h want 10000", bus.q); end
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL basic_empty got %b want 0", bus.empty); end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL basic_wr_ready got %b want 1", bus.wr_ready); end
    $display("test_basic_write usedw=%0d q=%h", bus.usedw, bus.q);
  endtask

  task automatic test_fill_overflow();
    step(1'b0, 18'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 18'(i), 1'b0, 1'b0);
    checks++; if (bus.full !== 1'b1 || bus.usedw !== 3'd0 || bus.wr_ready !== 1'b0 || bus.ovf !== 1'b0)
      begin errors++; $display("FAIL fill_flags full=%b usedw=%0d wr_ready=%b ovf=%b want 1 0 0 0", bus.full, bus.usedw, bus.wr_ready, bus.ovf); end
    step(1'b1, 18'h3FFFF, 1'b0, 1'b0);
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", bus.ovf); end
    checks++; if (bus.q !== 18'h0) begin errors++; $display("FAIL fill_q got %h want 0", bus.q); end
    checks++; if (bus.full !== 1'b1 || bus.usedw !== 3'd0) begin errors++; $display("FAIL fill_after9 full=%b usedw=%0d want 1 0", bus.full, bus.usedw); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.q !== 18'(i)) begin errors++; $display("FAIL drain_q[%0d] got %h want %h", i, bus.q, 18'(i)); end
      pop_once();
    end
    checks++; if (bus.empty !== 1'b1 || bus.ovf !== 1'b1) begin errors++; $display("FAIL drain_end empty=%b ovf=%b want 1 1", bus.empty, bus.ovf); end
    $display("test_fill_overflow done");
  endtask

  task automatic test_hold_read();
    logic [17:0] a, b, c;
    a = 18'($urandom); b = 18'($urandom); c = 18'($urandom);
    step(1'b0, 18'h0, 1'b0, 1'b1);
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, 1'b0);
    repeat (5) step(1'b0, 18'h0, 1'b1, 1'b0);
    checks++; if (bus.usedw !== 3'd2) begin errors++; $display("FAIL hold_usedw got %0d want 2", bus.usedw); end
    checks++; if (bus.q !== b) begin errors++; $display("FAIL hold_q got %h want %h", bus.q, b); end
    idle();
    $display("test_hold_read usedw=%0d", bus.usedw);
  endtask

  task automatic test_simul_mid();
    logic [17:0] d [4];
    logic [17:0] n;
    step(1'b0, 18'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin d[i] = 18'($urandom); step(1'b1, d[i], 1'b0, 1'b0); end
    n = 18'($urandom);
    step(1'b1, n, 1'b1, 1'b0);
    checks++; if (bus.usedw !== 3'd4) begin errors++; $display("FAIL simul_usedw got %0d want 4", bus.usedw); end
    checks++; if (bus.q !== d[1]) begin errors++; $display("FAIL simul_q got %h want %h", bus.q, d[1]); end
    idle();
    for (int i = 0; i < 3; i++) pop_once();
    checks++; if (bus.q !== n) begin errors++; $display("FAIL simul_last got %h want %h", bus.q, n); end
    pop_once();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL simul_empty got %b want 1", bus.empty); end
    $display("test_simul_mid done");
  endtask

  task automatic test_full_empty_simul();
    logic [17:0] x, y;
    x = 18'h3ABCD; y = 18'($urandom);
    step(1'b0, 18'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 18'(100 + i), 1'b0, 1'b0);
    step(1'b1, x, 1'b1, 1'b0);
    checks++; if (bus.usedw !== 3'd7 || bus.full !== 1'b0) begin errors++; $display("FAIL fullsim usedw=%0d full=%b want 7 0", bus.usedw, bus.full); end
    checks++; if (bus.q !== 18'd101) begin errors++; $display("FAIL fullsim_q got %h want %h", bus.q, 18'd101); end
    idle();
    for (int i = 0; i < 7; i++) begin
      checks++; if (bus.q !== 18'(101 + i)) begin errors++; $display("FAIL fullsim_drain[%0d] got %h want %h", i, bus.q, 18'(101 + i)); end
      pop_once();
    end
    step(1'b0, 18'h0, 1'b0, 1'b1);
    step(1'b1, y, 1'b1, 1'b0);
    checks++; if (bus.usedw !== 3'd1 || bus.q !== y) begin errors++; $display("FAIL emptysim usedw=%0d q=%h want 1 %h", bus.usedw, bus.q, y); end
    idle();
    $display("test_full_empty_simul done");
  endtask

  task automatic test_start_and_reset();
    step(1'b0, 18'h0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 18'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pop_once();
    checks++; if (bus.ovf !== 1'b1 || bus.usedw !== 3'd5) begin errors++; $display("FAIL pre_start ovf=%b usedw=%0d want 1 5", bus.ovf, bus.usedw); end
    step(1'b1, 18'h12345, 1'b0, 1'b1);
    checks++; if (bus.usedw !== 3'd0 || bus.empty !== 1'b1 || bus.ovf !== 1'b0)
      begin errors++; $display("FAIL start_flush usedw=%0d empty=%b ovf=%b want 0 1 0", bus.usedw, bus.empty, bus.ovf); end
    step(1'b1, 18'h00111, 1'b0, 1'b0);
    step(1'b1, 18'h00222, 1'b0, 1'b0);
    bus.res_valid = 1'b1; bus.res_data = 18'h00333;
    rst = 1'b0;
    #1;
    checks++; if (bus.empty !== 1'b1 || bus.usedw !== 3'd0) begin errors++; $display("FAIL async_rst empty=%b usedw=%0d want 1 0", bus.empty, bus.usedw); end
    @(posedge clk); #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_hold empty=%b want 1", bus.empty); end
    rst = 1'b1;
    model_reset();
    idle();
    checks++; if (bus.empty !== 1'b1 || bus.usedw !== 3'd0) begin errors++; $display("FAIL post_rst empty=%b usedw=%0d want 1 0", bus.empty, bus.usedw); end
    $display("test_start_and_reset done");
  endtask

  task automatic test_random();
    logic sv, rd, st;
    for (int n = 0; n < 400; n++) begin
      sv = ($urandom_range(0, 9) < 6);
      rd = $urandom_range(0, 1);
      st = ($urandom_range(0, 49) == 0);
      step(sv, 18'($urandom), rd, st);
      checks++;
      if (bus.usedw !== 3'(mq.size()) || bus.full !== (mq.size() == 8) || bus.empty !== (mq.size() == 0) ||
          bus.wr_ready !== (mq.size() != 8) || bus.ovf !== m_ovf) begin
        errors++;
        $display("FAIL rand_flags[%0d] usedw=%0d full=%b empty=%b ovf=%b want size=%0d ovf=%b",
                 n, bus.usedw, bus.full, bus.empty, bus.ovf, mq.size(), m_ovf);
      end
      if (mq.size() > 0) begin
        checks++;
        if (bus.q !== mq[0]) begin errors++; $display("FAIL rand_q[%0d] got %h want %h", n, bus.q, mq[0]); end
      end
    end
    $display("test_random done size=%0d", mq.size());
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_fill_overflow();
    test_hold_read();
    test_simul_mid();
    test_full_empty_simul();
    test_start_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp_result_buffer.md
EXP_RESULT_BUFFER -- requirements
Module: exp_result_buffer

Interface
REQ-001 The module SHALL declare parameter DATA_W, default 18, result width in Q2.16 (2 integer bits, 16 fraction bits).
REQ-002 The module SHALL declare parameter DEPTH, default 8, number of buffered results.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  synchronous flush at the start of a new batch.
REQ-006 res_valid  input  1  the accelerator presents a result this cycle.
REQ-007 res_data  input  DATA_W  result value, Q2.16.
REQ-008 wr_ready  output  1  the buffer can accept a result.
REQ-009 read  input  1  pop request, level from a debounced key.
REQ-010 q  output  DATA_W  head entry, show-ahead.
REQ-011 usedw  output  3  occupancy modulo 8.
REQ-012 full  output  1  occupancy equals DEPTH.
REQ-013 empty  output  1  occupancy equals 0.
REQ-014 ovf  output  1  sticky overflow flag.

Function
REQ-015 The module SHALL keep a 4-bit occupancy count in the range 0..8; usedw SHALL equal count[2:0], so usedw reads 0 when the buffer is full, and full disambiguates.
REQ-016 wr_ready SHALL equal !full, combinationally.
REQ-017 A write SHALL occur when res_valid && wr_ready: res_data is stored at wr_ptr, wr_ptr increments modulo 8, and count increments.
REQ-018 A pop event SHALL be read && !read_d, where read_d is read registered by one cycle, so one pop occurs per key press regardless of hold length.
REQ-019 A pop SHALL occur when a pop event coincides with !empty: rd_ptr increments modulo 8 and count decrements.
REQ-020 A pop event while empty SHALL be ignored, with no state change and ovf unaffected.
REQ-021 q SHALL show mem[rd_ptr] combinationally from the registered array; q SHALL be undefined-but-stable while empty, and the bench SHALL NOT check q when empty=1.
REQ-022 A write and a pop in the same cycle with 0 < count < 8 SHALL both be performed, leaving count unchanged and advancing both pointers.
REQ-023 With count==8, a simultaneous res_valid and pop event SHALL perform the pop only; the write SHALL be refused because wr_ready=0 that cycle.
REQ-024 With count==0, a simultaneous write and pop event SHALL perform the write only; q SHALL show the new data on the next cycle.
REQ-025 res_valid while full SHALL set ovf on the next edge; ovf SHALL stay set until start or reset.
REQ-026 start SHALL take priority over writes and pops in the same cycle: it SHALL clear wr_ptr, rd_ptr, count, and ovf; memory contents SHALL NOT be cleared.
REQ-027 Write latency SHALL be 1 cycle: data accepted on edge N SHALL be visible on q by edge N+1 if it is the head entry.
REQ-028 Pointers SHALL wrap from 7 to 0 with no bubble.

Reset
REQ-029 On rst=0, asynchronously: wr_ptr=0, rd_ptr=0, count=0, read_d=0, ovf=0.
REQ-030 During reset the outputs SHALL be: usedw=0, empty=1, full=0, wr_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries, with no write or pop completing on that edge.
REQ-032 Memory contents SHALL NOT be reset.

Structure
REQ-033 A shared package SHALL hold DATA_W=18, DEPTH=8, AW=3, and the Q2.16 field positions (integer [17:16], fraction [15:0]), for reuse by the display top level.
REQ-034 Storage SHALL be one sub-module, result_regfile: an 8x18 register array with one synchronous write port and one asynchronous read port, without reset.
REQ-035 Pointer, count, edge-detect, and flag logic SHALL reside in exp_result_buffer.
REQ-036 There SHALL be no FSM beyond the count; the design SHALL contain no latches.

Verification
REQ-037 Scenario: reset, then write 18'h10000, 18'h0B852, 18'h2A000 -> usedw=3, q=18'h10000, empty=0, wr_ready=1.
REQ-038 Scenario: fill with 8 writes of 0..7, then a 9th res_valid -> full=1, usedw=0, wr_ready=0, ovf=1 next cycle, q=0, and the 9th datum is never seen.
REQ-039 Scenario: with 3 entries, hold read high for 5 cycles -> exactly one pop, usedw=2, q shows the second entry.
REQ-040 Scenario: with 4 entries, apply a write and a pop event in the same cycle -> usedw stays 4, q advances, and the new datum appears last after 4 pops.
REQ-041 Scenario: with the buffer full, apply a pop event and res_valid together -> usedw=7, full=0, and the write is refused; with the buffer empty, apply both together -> usedw=1.
REQ-042 Scenario: assert start while ovf=1 and 5 entries are held, concurrently with res_valid -> next cycle usedw=0, empty=1, ovf=0, and the write is dropped; then assert rst mid-stream -> empty=1 immediately.
